// File: rtl/lcd_spi_pkg.sv
// Shared encodings for the 4-wire SPI display transmitter.
// FSM state codes and D/C flag levels used by lcd_spi_tx and its bench.
package lcd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    HOLD = 3'd3,
    GAP  = 3'd4
  } lcd_state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/lcd_spi_fifo.sv
// Synchronous word FIFO for the SPI transmitter (D/C flag carried in the MSB).
// Occupancy and full flag are registered; pointers wrap modulo DEPTH.
module lcd_spi_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_nxt;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + (AW+1)'(1);
    else if (pop && !push)
      level_nxt = level - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
    end
  end

  // Storage is data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (level == '0);

endmodule

// File: rtl/lcd_spi_tx.sv
// Buffered 4-wire SPI (mode 0) transmitter for display controllers.
// Words stream back to back under one CSX assertion while the FIFO stays non-empty.
module lcd_spi_tx
  import lcd_spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int LSB_FIRST  = 0
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [DATA_W-1:0]             IN_DATA,
  input  logic                          IN_DC,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          BUSY,
  output logic                          CSX,
  output logic                          DCX,
  output logic                          SCL,
  output logic                          SDA
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  lcd_state_t        state_q, state_nxt;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shreg_q;
  logic              dc_q;
  logic [DATA_W:0]   fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              load;
  logic              shift;
  logic              div_done;
  logic              last_bit;
  logic              cur_bit;
  logic              in_frame;

  assign push     = IN_VALID && !fifo_full;
  assign IN_READY = !fifo_full;
  assign div_done = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_q == BIT_W'(DATA_W - 1));
  assign cur_bit  = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[DATA_W-1];
  assign in_frame = (state_q == LOW) || (state_q == HIGH);

  lcd_spi_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .pop   (pop),
    .wdata ({IN_DC, IN_DATA}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (LEVEL)
  );

  always_comb begin
    state_nxt = state_q;
    pop       = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (div_done)
          state_nxt = HIGH;
      end
      HIGH: begin
        if (div_done) begin
          if (!last_bit) begin
            shift     = 1'b1;
            state_nxt = LOW;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            load      = 1'b1;
            state_nxt = LOW;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (div_done)
          state_nxt = GAP;
      end
      GAP: begin
        if (div_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control: state, half-period divider and bit counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == IDLE || state_nxt != state_q)
        div_q <= '0;
      else
        div_q <= div_q + DIV_W'(1);
      if (load)
        bit_q <= '0;
      else if (shift)
        bit_q <= bit_q + BIT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      shreg_q <= fifo_rdata[DATA_W-1:0];
      dc_q    <= fifo_rdata[DATA_W];
    end else if (shift) begin
      shreg_q <= (LSB_FIRST != 0) ? {1'b0, shreg_q[DATA_W-1:1]}
                                  : {shreg_q[DATA_W-2:0], 1'b0};
    end
  end

  // Output stage: pins follow the current state one cycle later, so SDA/DCX
  // move on the same edge that drives SCL low.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CSX  <= 1'b1;
      SCL  <= 1'b0;
      SDA  <= 1'b0;
      DCX  <= DC_CMD;
      BUSY <= 1'b0;
    end else begin
      CSX  <= !(in_frame || state_q == HOLD);
      SCL  <= (state_q == HIGH);
      SDA  <= in_frame ? cur_bit : 1'b0;
      if (in_frame)
        DCX <= dc_q;
      BUSY <= (state_nxt != IDLE) || push || !fifo_empty;
    end
  end

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Scoreboard bench for lcd_spi_tx: an 8-bit MSB-first instance (CLK_DIV=4)
// and a 16-bit LSB-first instance (CLK_DIV=1) share one clock and reset.
module tb_lcd_spi_tx;

  typedef struct {
    logic [15:0] data;
    logic        dc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic [7:0]  in_data8 = '0;
  logic        in_dc8 = 1'b0;
  logic        in_valid8 = 1'b0;
  logic        rdy8, busy8, csx8, dcx8, scl8, sda8;
  logic [4:0]  level8;

  logic [15:0] in_data16 = '0;
  logic        in_dc16 = 1'b0;
  logic        in_valid16 = 1'b0;
  logic        rdy16, busy16, csx16, dcx16, scl16, sda16;
  logic [4:0]  level16;

  int n_checks = 0;
  int n_fail = 0;
  int last_push_cyc = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  int          nb[2];
  int          last_rise[2];
  int          t_csx_fall[2];
  int          t_csx_rise[2];
  int          t_scl_fall[2];
  logic        p_scl[2];
  logic        p_csx[2];
  logic        p_dcx[2];
  logic [15:0] bits[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_spi_tx #(.DATA_W(8), .CLK_DIV(4), .FIFO_DEPTH(16), .LSB_FIRST(0)) u_dut8 (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data8), .IN_DC(in_dc8),
    .IN_VALID(in_valid8), .IN_READY(rdy8), .LEVEL(level8), .BUSY(busy8),
    .CSX(csx8), .DCX(dcx8), .SCL(scl8), .SDA(sda8)
  );

  lcd_spi_tx #(.DATA_W(16), .CLK_DIV(1), .FIFO_DEPTH(16), .LSB_FIRST(1)) u_dut16 (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data16), .IN_DC(in_dc16),
    .IN_VALID(in_valid16), .IN_READY(rdy16), .LEVEL(level16), .BUSY(busy16),
    .CSX(csx16), .DCX(dcx16), .SCL(scl16), .SDA(sda16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: decodes each SCL rise, rebuilds words and pops the scoreboard.
  task automatic mon_step(input int idx, input logic csx, input logic scl, input logic sda,
                          input logic dcx, input int dw, input int div, input bit lsb);
    exp_t e;
    bit   have;
    if (!rst_n) begin
      nb[idx] = 0;
      last_rise[idx] = -1;
    end else begin
      if (p_csx[idx] && !csx) t_csx_fall[idx] = cyc;
      if (!p_csx[idx] && csx) t_csx_rise[idx] = cyc;
      if (p_scl[idx] && !scl) t_scl_fall[idx] = cyc;
      if (csx) last_rise[idx] = -1;
      if (dcx !== p_dcx[idx]) check($sformatf("dcx_change_scl_low_%0d", idx), scl, 0);
      if (!p_scl[idx] && scl) begin
        check($sformatf("csx_low_at_rise_%0d", idx), csx, 0);
        if (last_rise[idx] >= 0)
          check($sformatf("scl_period_%0d", idx), cyc - last_rise[idx], 2 * div);
        last_rise[idx] = cyc;
        if (nb[idx] == 0) bits[idx] = '0;
        if (lsb) bits[idx][nb[idx]] = sda;
        else     bits[idx][dw-1-nb[idx]] = sda;
        have = (idx == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
        if (!have) begin
          check($sformatf("unexpected_bit_%0d", idx), 0, 1);
        end else begin
          e = (idx == 0) ? sb0[0] : sb1[0];
          check($sformatf("dcx_level_%0d", idx), dcx, e.dc);
          nb[idx]++;
          if (nb[idx] == dw) begin
            check($sformatf("word_%0d", idx), bits[idx], e.data);
            if (idx == 0) void'(sb0.pop_front());
            else          void'(sb1.pop_front());
            nb[idx] = 0;
          end
        end
      end
    end
    p_csx[idx] = csx;
    p_scl[idx] = scl;
    p_dcx[idx] = dcx;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0; last_rise[i] = -1; t_csx_fall[i] = 0; t_csx_rise[i] = 0;
      t_scl_fall[i] = 0; p_scl[i] = 1'b0; p_csx[i] = 1'b1; p_dcx[i] = 1'b0; bits[i] = '0;
    end
  end

  always @(negedge clk) begin
    mon_step(0, csx8, scl8, sda8, dcx8, 8, 4, 1'b0);
    mon_step(1, csx16, scl16, sda16, dcx16, 16, 1, 1'b1);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int idx, input logic [15:0] d, input logic dc);
    exp_t e;
    logic r;
    int   n;
    @(negedge clk);
    #1;
    if (idx == 0) begin in_valid8 = 1'b1; in_data8 = d[7:0]; in_dc8 = dc; end
    else          begin in_valid16 = 1'b1; in_data16 = d; in_dc16 = dc; end
    n = 0;
    forever begin
      r = (idx == 0) ? rdy8 : rdy16;
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 2000) begin
        check("send_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      #1;
    end
    #1;
    last_push_cyc = cyc;
    e.data = d;
    e.dc = dc;
    if (idx == 0) sb0.push_back(e);
    else          sb1.push_back(e);
  endtask

  task automatic release_in;
    tick;
    in_valid8 = 1'b0;
    in_valid16 = 1'b0;
  endtask

  task automatic wait_idle(input int idx, input int bound);
    int  n;
    logic b;
    for (n = 0; n < bound; n++) begin
      tick;
      b = (idx == 0) ? busy8 : busy16;
      if (!b) break;
    end
    if (n >= bound) check($sformatf("idle_timeout_%0d", idx), 0, 1);
    check($sformatf("scoreboard_drained_%0d", idx), (idx == 0) ? sb0.size() : sb1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rise_a;
    int   n;
    logic bad;

    // Reset state.
    tick; tick;
    check("rst_csx", csx8, 1);
    check("rst_scl", scl8, 0);
    check("rst_sda", sda8, 0);
    check("rst_dcx", dcx8, 0);
    check("rst_ready", rdy8, 1);
    check("rst_busy", busy8, 0);
    check("rst_level", level8, 0);
    check("rst_csx16", csx16, 1);
    check("rst_level16", level16, 0);
    rst_n = 1'b1;
    tick; tick;

    // Single command 0x2A: latency and frame tail.
    send(0, 16'h002A, 1'b0);
    release_in;
    wait_idle(0, 500);
    check("latency_push_to_csx", t_csx_fall[0] - last_push_cyc, 2);
    check("tail_sclfall_to_csx", t_csx_rise[0] - t_scl_fall[0], 4);
    repeat (4) tick;
    check("deselect_hold", csx8, 1);

    // Burst 0x2C cmd then 0xF8, 0x00 data under one CSX.
    send(0, 16'h002C, 1'b0);
    send(0, 16'h00F8, 1'b1);
    send(0, 16'h0000, 1'b1);
    release_in;
    wait_idle(0, 1000);
    check("burst_csx_low_span", t_csx_rise[0] - t_csx_fall[0], 196);

    // Push while in GAP.
    send(0, 16'h005A, 1'b1);
    release_in;
    rise_a = t_csx_rise[0];
    for (n = 0; n < 500 && t_csx_rise[0] == rise_a; n++) tick;
    if (n >= 500) check("gap_wait_timeout", 0, 1);
    rise_a = t_csx_rise[0];
    send(0, 16'h00A5, 1'b0);
    release_in;
    wait_idle(0, 500);
    check("gap_min_deselect", (t_csx_fall[0] - rise_a) >= 4, 1);

    // Fill the FIFO while one word is on the wire.
    send(0, 16'h0011, 1'b1);
    release_in;
    for (n = 0; n < 50 && !(level8 == 0 && csx8 == 0); n++) tick;
    if (n >= 50) check("fill_start_timeout", 0, 1);
    for (int i = 0; i < 16; i++) send(0, 16'h0040 + 16'(i), 1'b1);
    release_in;
    check("fill_level16", level8, 16);
    check("fill_ready_low", rdy8, 0);
    in_valid8 = 1'b1; in_data8 = 8'h77; in_dc8 = 1'b0;
    repeat (5) begin
      tick;
      check("full_no_accept", level8, 16);
    end
    for (n = 0; n < 200 && !rdy8; n++) tick;
    if (n >= 200) check("fill_pop_timeout", 0, 1);
    check("ready_after_pop_level", level8, 15);
    @(posedge clk);
    #1;
    sb0.push_back('{data: 16'h0077, dc: 1'b0});
    tick;
    in_valid8 = 1'b0;
    check("refill_level", level8, 16);
    wait_idle(0, 3000);

    // Reset mid-word with five words queued.
    for (int i = 0; i < 6; i++) send(0, 16'h00C0 + 16'(i), 1'b1);
    release_in;
    for (n = 0; n < 500 && nb[0] != 3; n++) tick;
    if (n >= 500) check("reset_bit3_timeout", 0, 1);
    rst_n = 1'b0;
    sb0.delete();
    #1;
    check("midrst_csx", csx8, 1);
    check("midrst_scl", scl8, 0);
    check("midrst_sda", sda8, 0);
    check("midrst_level", level8, 0);
    tick; tick;
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      tick;
      if (scl8 !== 1'b0 || csx8 !== 1'b1 || busy8 !== 1'b0) bad = 1'b1;
    end
    check("post_reset_quiet", bad, 0);
    send(0, 16'h003C, 1'b0);
    release_in;
    wait_idle(0, 500);

    // 16-bit LSB-first, CLK_DIV=1.
    send(1, 16'h8001, 1'b1);
    release_in;
    wait_idle(1, 200);
    check("w16_csx_low_span", t_csx_rise[1] - t_csx_fall[1], 33);
    send(1, 16'h00F1, 1'b0);
    release_in;
    wait_idle(1, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
